// File: rtl/key_dir_queue.sv
// key_dir_queue: per-player debounced 4-key pad feeding a reverse-free pending-turn FIFO
// Ports: clk, rst (sync, active high); key_up/key_down/key_left/key_right raw keys, bit p = player p;
// step_tick pops one queued turn per non-empty player; direction[2p+1:2p] current direction;
// queue_count per-player pending entries; turn_dropped pulses when a valid turn meets a full queue.
// Direction codes: 0 top, 1 down, 2 left, 3 right (key index matches its direction code).
module key_dir_queue #(
  parameter int NUM_PLAYERS = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [1:0] INIT_DIR = 2'd0
)(
  input  logic clk,
  input  logic rst,
  input  logic [NUM_PLAYERS-1:0] key_up,
  input  logic [NUM_PLAYERS-1:0] key_down,
  input  logic [NUM_PLAYERS-1:0] key_left,
  input  logic [NUM_PLAYERS-1:0] key_right,
  input  logic step_tick,
  output logic [2*NUM_PLAYERS-1:0] direction,
  output logic [NUM_PLAYERS*$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic [NUM_PLAYERS-1:0] turn_dropped
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES+1);
  localparam int QW = $clog2(QUEUE_DEPTH+1);
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
    logic [3:0] raw, s1, s2, deb, deb_d, rise;
    logic [CW-1:0] cnt [4];
    logic ev, pop, full, valid, push, drop, dropped;
    logic [1:0] ev_dir, dir, ref_dir;
    logic [1:0] mem [QUEUE_DEPTH];
    logic [PW-1:0] head, tail, last_idx, head_nx, tail_nx;
    logic [QW-1:0] count;
    assign raw = {key_right[p], key_left[p], key_down[p], key_up[p]};
    assign rise = deb & ~deb_d;
    assign last_idx = tail == '0 ? PW'(QUEUE_DEPTH-1) : tail - 1'b1;
    assign head_nx = head == PW'(QUEUE_DEPTH-1) ? '0 : head + 1'b1;
    assign tail_nx = tail == PW'(QUEUE_DEPTH-1) ? '0 : tail + 1'b1;
    // new turns are judged against the newest pending turn, not the live direction
    assign ref_dir = count != '0 ? mem[last_idx] : dir;
    assign pop = step_tick && count != '0;
    assign full = count == QW'(QUEUE_DEPTH);
    assign valid = ev && ev_dir != ref_dir && ev_dir != (ref_dir ^ 2'b01);
    assign push = valid && (!full || pop);
    assign drop = valid && full && !pop;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= '0;
        s2 <= '0;
        deb <= '0;
        deb_d <= '0;
        ev <= 1'b0;
        ev_dir <= '0;
        for (int k = 0; k < 4; k++) cnt[k] <= '0;
      end else begin
        s1 <= raw;
        s2 <= s1;
        deb_d <= deb;
        // a press counts only as a lone key: its rise is the sole set debounced level
        ev <= $onehot(rise) && deb == rise;
        ev_dir <= {rise[3] | rise[2], rise[3] | rise[1]};
        for (int k = 0; k < 4; k++) begin
          if (s2[k] == deb[k]) cnt[k] <= '0;
          else if (cnt[k] == CW'(DEBOUNCE_CYCLES-1)) begin
            deb[k] <= s2[k];
            cnt[k] <= '0;
          end else cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        dir <= INIT_DIR;
        head <= '0;
        tail <= '0;
        count <= '0;
        dropped <= 1'b0;
      end else begin
        dropped <= drop;
        if (pop) begin
          dir <= mem[head];
          head <= head_nx;
        end
        if (push) tail <= tail_nx;
        count <= count + QW'(push) - QW'(pop);
      end
    end
    always_ff @(posedge clk) if (!rst && push) mem[tail] <= ev_dir;
    assign direction[2*p +: 2] = dir;
    assign queue_count[QW*p +: QW] = count;
    assign turn_dropped[p] = dropped;
  end
endmodule

// File: tb/tb_key_dir_queue.sv
// tb_key_dir_queue: directed stimulus against a window/queue model of key_dir_queue
module tb_key_dir_queue;
  localparam int NP = 2;
  localparam int D = 4;
  localparam int QD = 2;
  localparam int QW = $clog2(QD+1);
  localparam logic [1:0] TOP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
  logic clk = 0, rst = 1, step = 0, chk_en = 0;
  logic [NP-1:0] kup = 0, kdn = 0, klf = 0, krt = 0, td;
  logic [2*NP-1:0] dir;
  logic [NP*QW-1:0] qc;
  int checks = 0, errors = 0;
  int drop_cnt [NP];
  logic [1:0] m_dir [NP];
  logic [1:0] m_qv [NP][QD];
  int m_n [NP];
  logic m_drop [NP], m_ev [NP];
  logic [1:0] m_evd [NP];
  logic [3:0] m_deb [NP], m_debp [NP];
  logic [D:0] m_hist [NP][4];

  key_dir_queue #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(D), .QUEUE_DEPTH(QD), .INIT_DIR(TOP)) dut (
    .clk(clk), .rst(rst), .key_up(kup), .key_down(kdn), .key_left(klf), .key_right(krt),
    .step_tick(step), .direction(dir), .queue_count(qc), .turn_dropped(td)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] opp(input logic [1:0] d);
    case (d)
      TOP: return DOWN;
      DOWN: return TOP;
      LEFT: return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  // Model: a key's debounced level flips once its last D synchronised samples
  // (raw samples two edges old and older) all disagree with it; a lone rising
  // level is registered as an event one edge later and queued the edge after.
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      logic [3:0] raw, rise;
      logic [1:0] r;
      logic val, pop;
      raw = {krt[p], klf[p], kdn[p], kup[p]};
      if (rst) begin
        m_dir[p] = TOP;
        m_n[p] = 0;
        m_drop[p] = 0;
        m_ev[p] = 0;
        m_evd[p] = 0;
        m_deb[p] = 0;
        m_debp[p] = 0;
        for (int k = 0; k < 4; k++) m_hist[p][k] = '0;
      end else begin
        r = m_n[p] > 0 ? m_qv[p][m_n[p]-1] : m_dir[p];
        val = m_ev[p] && m_evd[p] != r && m_evd[p] != opp(r);
        pop = step && m_n[p] > 0;
        m_drop[p] = 0;
        if (pop) begin
          m_dir[p] = m_qv[p][0];
          for (int i = 0; i < QD-1; i++) m_qv[p][i] = m_qv[p][i+1];
          m_n[p]--;
        end
        if (val) begin
          if (m_n[p] < QD) begin
            m_qv[p][m_n[p]] = m_evd[p];
            m_n[p]++;
          end else m_drop[p] = 1;
        end
        rise = m_deb[p] & ~m_debp[p];
        m_ev[p] = $countones(rise) == 1 && m_deb[p] == rise;
        for (int k = 0; k < 4; k++) if (rise[k]) m_evd[p] = 2'(k);
        m_debp[p] = m_deb[p];
        for (int k = 0; k < 4; k++) begin
          if (m_hist[p][k][D:1] == {D{~m_deb[p][k]}}) m_deb[p][k] = ~m_deb[p][k];
          m_hist[p][k] = {m_hist[p][k][D-1:0], raw[k]};
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("model_dir_p%0d", p), int'(dir[2*p +: 2]), int'(m_dir[p]));
        chk($sformatf("model_count_p%0d", p), int'(qc[QW*p +: QW]), m_n[p]);
        chk($sformatf("model_drop_p%0d", p), int'(td[p]), int'(m_drop[p]));
        if (td[p]) drop_cnt[p]++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int p, input int k, input logic v);
    case (k)
      0: kup[p] = v;
      1: kdn[p] = v;
      2: klf[p] = v;
      default: krt[p] = v;
    endcase
  endtask

  task automatic tap(input int p, input int k);
    set_key(p, k, 1);
    cyc(8);
    set_key(p, k, 0);
    cyc(8);
  endtask

  task automatic tick();
    step = 1;
    cyc(1);
    step = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc(1);
    chk_en = 1;
    drop_cnt = '{0, 0};
    cyc(1);
    rst = 0;
    cyc(1);
  endtask

  function automatic int c0();
    return int'(qc[QW-1:0]);
  endfunction

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_dir_p0", int'(dir[1:0]), TOP);
    chk("reset_count_p0", c0(), 0);
    // latency and first pop
    klf[0] = 1;
    cyc(7);
    chk("t1_count_before", c0(), 0);
    cyc(1);
    chk("t1_count_at_edge7", c0(), 1);
    cyc(2);
    klf[0] = 0;
    cyc(8);
    tick();
    chk("t1_dir_p0", int'(dir[1:0]), LEFT);
    chk("t1_count_after_pop", c0(), 0);
    chk("t1_dir_p1", int'(dir[3:2]), TOP);
    // bounce shorter than the debounce window
    do_reset();
    klf[0] = 1;
    cyc(2);
    klf[0] = 0;
    cyc(10);
    chk("t2_count", c0(), 0);
    chk("t2_dir", int'(dir[1:0]), TOP);
    // reverse and same-direction presses are discarded silently
    tap(0, 1);
    tap(0, 0);
    chk("t3_count", c0(), 0);
    chk("t3_no_drop", drop_cnt[0], 0);
    chk("t3_dir", int'(dir[1:0]), TOP);
    // fill then overflow
    do_reset();
    tap(0, 2);
    tap(0, 1);
    chk("t4_full_count", c0(), 2);
    tap(0, 3);
    chk("t4_drop_once", drop_cnt[0], 1);
    chk("t4_count_after_drop", c0(), 2);
    tick();
    chk("t4_pop1_dir", int'(dir[1:0]), LEFT);
    chk("t4_pop1_count", c0(), 1);
    tick();
    chk("t4_pop2_dir", int'(dir[1:0]), DOWN);
    chk("t4_pop2_count", c0(), 0);
    // push and pop together on a full queue
    do_reset();
    tap(0, 2);
    tap(0, 1);
    krt[0] = 1;
    cyc(7);
    step = 1;
    cyc(1);
    step = 0;
    chk("t5_count", c0(), 2);
    chk("t5_dir", int'(dir[1:0]), LEFT);
    chk("t5_no_drop_now", int'(td[0]), 0);
    cyc(1);
    krt[0] = 0;
    cyc(8);
    chk("t5_no_drop", drop_cnt[0], 0);
    tick();
    chk("t5_pop_down", int'(dir[1:0]), DOWN);
    tick();
    chk("t5_pop_right", int'(dir[1:0]), RIGHT);
    // chord ignored, independent player, reset discards queue
    do_reset();
    tap(0, 2);
    tap(0, 1);
    kup[0] = 1;
    klf[0] = 1;
    klf[1] = 1;
    cyc(8);
    kup[0] = 0;
    klf[0] = 0;
    klf[1] = 0;
    cyc(8);
    chk("t6_chord_count_p0", c0(), 2);
    chk("t6_count_p1", int'(qc[2*QW-1:QW]), 1);
    rst = 1;
    cyc(1);
    chk("t6_rst_dir", int'(dir[1:0]), TOP);
    chk("t6_rst_count_p0", c0(), 0);
    chk("t6_rst_count_p1", int'(qc[2*QW-1:QW]), 0);
    chk("t6_rst_drop", int'(td[0]), 0);
    rst = 0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_dir_queue.md
Name: key_dir_queue

Overview:
- Parametrised successor to the single-player snake direction latch.
- Handles NUM_PLAYERS independent 4-key pads with per-key synchronisation, debounce and press-edge detection.
- Keeps a per-player FIFO of pending turns, so quick double-taps (e.g. UP then LEFT within one game step) are not lost.
- Sits between board buttons and the game-logic step engine; the engine pulses step_tick once per snake move to consume one queued turn per player.

Parameters:
- NUM_PLAYERS, 1: number of independent key pads / direction outputs.
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks needed before a debounced key level changes.
- QUEUE_DEPTH, 4: pending-turn FIFO entries per player (>=1).
- INIT_DIR, TOP_DIR: direction loaded on reset (2-bit code from the shared define header).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- key_up  input  NUM_PLAYERS  raw active-high up key; bit p = player p
- key_down  input  NUM_PLAYERS  raw down key
- key_left  input  NUM_PLAYERS  raw left key
- key_right  input  NUM_PLAYERS  raw right key
- step_tick  input  1  one-clock pulse from game engine; pops one entry per non-empty player queue
- direction  output  2*NUM_PLAYERS  current direction; bits [2p+1:2p] = player p; TOP_DIR/DOWN_DIR/LEFT_DIR/RIGHT_DIR codes
- queue_count  output  NUM_PLAYERS*$clog2(QUEUE_DEPTH+1)  pending entries per player
- turn_dropped  output  NUM_PLAYERS  one-clock pulse when a valid press is discarded because the queue is full

Behaviour:
- Reset (sync, rst high at posedge):
  - direction = INIT_DIR for all players.
  - Queues empty, queue_count = 0, turn_dropped = 0.
  - Synchronisers, debounced levels and counters cleared to 0.
  - Reset mid-operation discards all queued turns.
- Synchronise: each raw key passes through a 2-flop synchroniser.
- Debounce, per key:
  - Counter increments while the synced level != the debounced level.
  - Counter clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synced value and the counter clears.
- Press event, per player: exactly one key's debounced level rises 0->1 this cycle AND the other three debounced levels are 0. Any other combination produces no event (multi-key chords ignored, release ignored).
- Reference direction R = last queued entry if queue non-empty, else the current direction register (pre-update value).
- Validity: an event for direction D is valid if D != R and D != opposite(R). Opposites: TOP<->DOWN, LEFT<->RIGHT. Invalid events are silently discarded (no turn_dropped).
- Push: a valid event is written to the tail next clock.
  - If the queue is full and no pop occurs this cycle, the event is discarded and turn_dropped pulses.
- Pop: on step_tick with a non-empty queue, the head moves into the direction register next clock. An empty queue leaves direction unchanged.
- Simultaneous push and pop in the same cycle: both performed and count unchanged. This holds even when the queue is full, so no drop occurs.
  - With count==1, R is the entry being popped.
- Latency: a raw key first sampled high at edge 0 and held yields a press event at edge DEBOUNCE_CYCLES+2. The entry is visible in queue_count at edge DEBOUNCE_CYCLES+3.
- Players are fully independent. step_tick is shared.
- Counters and pointers wrap modulo QUEUE_DEPTH. queue_count never exceeds QUEUE_DEPTH.

Test Plan:
Common setup: NUM_PLAYERS=2, DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, INIT_DIR=TOP_DIR.
1. Reset, then p0 key_left held 10 clocks -> queue_count[p0] becomes 1 exactly 7 edges after first sample. step_tick -> direction[p0]=LEFT_DIR, count 0. p1 stays TOP_DIR.
2. p0 key_left pulsed for 2 clocks (bounce) -> no event, queue_count 0, direction TOP_DIR.
3. From TOP_DIR, empty queue: press DOWN, then press TOP -> both discarded, count 0, turn_dropped never asserts.
4. Queue fill: press LEFT, then DOWN (count 2), then RIGHT -> RIGHT discarded as reverse-free but full, turn_dropped one-clock pulse. Two step_ticks -> direction LEFT_DIR then DOWN_DIR.
5. Full queue [LEFT,DOWN], step_tick in the same cycle as a RIGHT press event -> no drop, queue [DOWN,RIGHT], direction LEFT_DIR.
6. p0 key_up and key_left held together -> no event. rst asserted with count 2 -> next clock direction=TOP_DIR, count 0, turn_dropped 0.
